// File: rtl/filler_pkg.sv
// Shared encodings for the fill/border control block: fill modes, register map, STATUS layout, FSM states.
// Pure definitions; no logic, no latency, no flow control.
package filler_pkg;

  localparam int CNT_W        = 12;
  localparam int ST_LINES_LSB = 0;
  localparam int ST_SHORT_LSB = 12;
  localparam int ST_IRQ_BIT   = 24;

  typedef enum logic [1:0] {
    MODE_RSVD   = 2'b00,
    MODE_BLACK  = 2'b01,
    MODE_WHITE  = 2'b10,
    MODE_CUSTOM = 2'b11
  } fill_mode_e;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_COLOR  = 2'd1,
    REG_STATUS = 2'd2,
    REG_FRAMES = 2'd3
  } reg_addr_e;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } fsm_state_e;

  // The reserved mode code is treated as black everywhere it is committed or compared.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == MODE_RSVD) ? MODE_BLACK : mode;
  endfunction

endpackage

// File: rtl/filler_ctrl_if.sv
// Register bus, sensor sync inputs and filler control outputs of filler_ctrl.
// master = CPU/sensor side, slave = filler_ctrl.
interface filler_ctrl_if;
  logic        cfg_wr;
  logic        cfg_rd;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        pre_vs;
  logic        pre_de;
  logic        fill_en;
  logic [1:0]  fill_mode;
  logic [23:0] fill_color;
  logic        busy;
  logic        irq;

  modport master (
    output cfg_wr, cfg_rd, cfg_addr, cfg_wdata, pre_vs, pre_de,
    input  cfg_rdata, fill_en, fill_mode, fill_color, busy, irq
  );

  modport slave (
    input  cfg_wr, cfg_rd, cfg_addr, cfg_wdata, pre_vs, pre_de,
    output cfg_rdata, fill_en, fill_mode, fill_color, busy, irq
  );
endinterface

// File: rtl/filler_ctrl_line_meter.sv
// Measures line lengths from pre_de, counts lines/short lines, latches both into STATUS on vs_pedge.
// STATUS valid the cycle after vs_pedge; no flow control, every pixel cycle is consumed.
module filler_ctrl_line_meter
  import filler_pkg::*;
#(
  parameter logic [CNT_W-1:0] H_DISP = 12'd1280
) (
  input  logic             pre_clk,
  input  logic             rst_n,
  input  logic             pre_de_i,
  input  logic             vs_pedge_i,
  output logic [CNT_W-1:0] st_lines_o,
  output logic [CNT_W-1:0] st_short_o,
  output logic             frame_short_o
);

  logic             de_d1_q;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] short_q, short_d;
  logic [CNT_W-1:0] st_lines_q, st_short_q;
  logic             de_pedge, de_nedge;

  assign de_pedge = pre_de_i & ~de_d1_q;
  assign de_nedge = ~pre_de_i & de_d1_q;

  // line_d/short_d include a line ending this cycle, so a coincident vs_pedge latches it.
  always_comb begin
    pix_d   = pix_q;
    line_d  = line_q;
    short_d = short_q;
    if (de_pedge) begin
      pix_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (pre_de_i && (pix_q != '1)) begin
      pix_d = pix_q + 1'b1;
    end
    if (de_nedge) begin
      if (line_q != '1) line_d = line_q + 1'b1;
      if ((pix_q < H_DISP) && (short_q != '1)) short_d = short_q + 1'b1;
    end
  end

  always_ff @(posedge pre_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_d1_q    <= 1'b0;
      pix_q      <= '0;
      line_q     <= '0;
      short_q    <= '0;
      st_lines_q <= '0;
      st_short_q <= '0;
    end else begin
      de_d1_q <= pre_de_i;
      pix_q   <= pix_d;
      if (vs_pedge_i) begin
        st_lines_q <= line_d;
        st_short_q <= short_d;
        line_q     <= '0;
        short_q    <= '0;
      end else begin
        line_q  <= line_d;
        short_q <= short_d;
      end
    end
  end

  assign st_lines_o    = st_lines_q;
  assign st_short_o    = st_short_q;
  assign frame_short_o = (short_d != '0);

endmodule

// File: rtl/filler_ctrl.sv
// Shadow register file with frame-synchronous commit of fill enable/mode/colour, hold FSM and short-line IRQ.
// Commit visible the cycle after pre_vs rises, reads one cycle after cfg_rd; no backpressure.
module filler_ctrl
  import filler_pkg::*;
#(
  parameter logic [11:0] H_DISP     = 12'd1280,
  parameter logic [3:0]  MIN_FRAMES = 4'd4
) (
  input  logic         pre_clk,
  input  logic         rst_n,
  filler_ctrl_if.slave bus
);

  logic             vs_d1_q, vs_pedge;
  logic             sh_en_q, sh_irq_en_q;
  logic [1:0]       sh_mode_q;
  logic [23:0]      sh_color_q;
  logic             fill_en_q;
  logic [1:0]       fill_mode_q;
  logic [23:0]      fill_color_q;
  logic [3:0]       hold_q;
  fsm_state_e       state_q;
  logic [15:0]      frames_q;
  logic             irq_q, irq_set, irq_clr, frames_clr;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] st_lines, st_short;
  logic             frame_short;
  logic             unused_wdata;

  assign vs_pedge     = bus.pre_vs & ~vs_d1_q;
  assign irq_set      = vs_pedge & sh_irq_en_q & frame_short;
  assign irq_clr      = bus.cfg_wr & (bus.cfg_addr == REG_STATUS) & bus.cfg_wdata[ST_IRQ_BIT];
  assign frames_clr   = bus.cfg_wr & (bus.cfg_addr == REG_FRAMES);
  assign unused_wdata = ^bus.cfg_wdata[31:25];

  filler_ctrl_line_meter #(.H_DISP(H_DISP)) u_meter (
    .pre_clk       (pre_clk),
    .rst_n         (rst_n),
    .pre_de_i      (bus.pre_de),
    .vs_pedge_i    (vs_pedge),
    .st_lines_o    (st_lines),
    .st_short_o    (st_short),
    .frame_short_o (frame_short)
  );

  always_comb begin
    rdata_d = '0;
    case (bus.cfg_addr)
      REG_CTRL:  rdata_d[3:0]  = {sh_irq_en_q, sh_mode_q, sh_en_q};
      REG_COLOR: rdata_d[23:0] = sh_color_q;
      REG_STATUS: begin
        rdata_d[ST_LINES_LSB +: CNT_W] = st_lines;
        rdata_d[ST_SHORT_LSB +: CNT_W] = st_short;
        rdata_d[ST_IRQ_BIT]            = irq_q;
      end
      default:   rdata_d[15:0] = frames_q;
    endcase
  end

  // Commit samples the shadows before a same-cycle write lands, deferring that write a frame.
  always_ff @(posedge pre_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1_q      <= 1'b0;
      sh_en_q      <= 1'b0;
      sh_irq_en_q  <= 1'b0;
      sh_mode_q    <= 2'b00;
      sh_color_q   <= '0;
      fill_mode_q  <= MODE_BLACK;
      fill_color_q <= '0;
      frames_q     <= '0;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      vs_d1_q <= bus.pre_vs;
      if (bus.cfg_wr) begin
        case (bus.cfg_addr)
          REG_CTRL: begin
            sh_en_q     <= bus.cfg_wdata[0];
            sh_mode_q   <= bus.cfg_wdata[2:1];
            sh_irq_en_q <= bus.cfg_wdata[3];
          end
          REG_COLOR: sh_color_q <= bus.cfg_wdata[23:0];
          default: ;
        endcase
      end
      if (vs_pedge) begin
        fill_mode_q  <= norm_mode(sh_mode_q);
        fill_color_q <= sh_color_q;
      end
      if (frames_clr)                 frames_q <= '0;
      else if (vs_pedge && fill_en_q) frames_q <= frames_q + 16'd1;
      if (irq_set)      irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
      if (bus.cfg_rd) rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge pre_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      fill_en_q <= 1'b0;
      hold_q    <= '0;
    end else if (vs_pedge) begin
      case (state_q)
        ST_OFF: begin
          if (sh_en_q) begin
            state_q   <= ST_ON;
            fill_en_q <= 1'b1;
            hold_q    <= MIN_FRAMES - 4'd1;
          end
        end
        ST_ON: begin
          if (hold_q != 4'd0) begin
            hold_q <= hold_q - 4'd1;
          end else if (!sh_en_q) begin
            state_q   <= ST_OFF;
            fill_en_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_OFF;
          fill_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fill_en    = fill_en_q;
  assign bus.fill_mode  = fill_mode_q;
  assign bus.fill_color = fill_color_q;
  assign bus.busy       = (sh_en_q != fill_en_q) | (norm_mode(sh_mode_q) != fill_mode_q) |
                          (sh_color_q != fill_color_q);
  assign bus.irq        = irq_q;
  assign bus.cfg_rdata  = rdata_q;

endmodule

// File: tb/tb_filler_ctrl.sv
// Scoreboard bench: the driver updates a frame-level reference model and queues per-cycle expectations;
// a negedge monitor pops and compares them with the DUT outputs.
module tb_filler_ctrl;
  localparam int H    = 16;
  localparam int MINF = 4;

  logic pre_clk = 1'b0;
  logic rst_n;
  always #5 pre_clk = ~pre_clk;

  filler_ctrl_if bus();

  filler_ctrl #(.H_DISP(12'd16), .MIN_FRAMES(4'd4)) dut (
    .pre_clk (pre_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          cyc;
    bit          en;
    bit [1:0]    mode;
    bit [23:0]   color;
    bit          busy;
    bit          irq;
    bit          rd_chk;
    bit [31:0]   rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge pre_clk) cyc <= cyc + 1;

  // Reference model state
  bit        m_sh_en, m_sh_irqen;
  bit [1:0]  m_sh_mode;
  bit [23:0] m_sh_color;
  bit        m_en;
  bit [1:0]  m_mode;
  bit [23:0] m_color;
  int        m_on_edges, m_frames;
  bit        m_irq;
  int        m_st_lines, m_st_short;
  int        m_lens[$];
  int        m_cur_len;
  bit        m_pvs, m_pde;

  function automatic bit [1:0] eff_mode(bit [1:0] m);
    return (m == 2'b00) ? 2'b01 : m;
  endfunction

  function automatic void m_reset();
    m_sh_en = 0; m_sh_irqen = 0; m_sh_mode = 2'b00; m_sh_color = '0;
    m_en = 0; m_mode = 2'b01; m_color = '0; m_on_edges = 0; m_frames = 0;
    m_irq = 0; m_st_lines = 0; m_st_short = 0; m_lens.delete(); m_cur_len = 0;
    m_pvs = 0; m_pde = 0;
  endfunction

  function automatic bit [31:0] read_reg(bit [1:0] a);
    bit [31:0] r;
    bit [11:0] l, s;
    bit [15:0] f;
    r = '0;
    l = 12'(m_st_lines);
    s = 12'(m_st_short);
    f = 16'(m_frames);
    case (a)
      2'd0:    r[3:0]  = {m_sh_irqen, m_sh_mode, m_sh_en};
      2'd1:    r[23:0] = m_sh_color;
      2'd2:    r       = {7'd0, m_irq, s, l};
      default: r[15:0] = f;
    endcase
    return r;
  endfunction

  function automatic exp_t snap(int c, bit chk, bit [31:0] rdv);
    exp_t e;
    e.cyc    = c;
    e.en     = m_en;
    e.mode   = m_mode;
    e.color  = m_color;
    e.busy   = (m_sh_en != m_en) || (eff_mode(m_sh_mode) != m_mode) || (m_sh_color != m_color);
    e.irq    = m_irq;
    e.rd_chk = chk;
    e.rdata  = rdv;
    return e;
  endfunction

  // One clock of behaviour, given the inputs sampled at the coming edge.
  task automatic model_step(input bit vs, de, wr, rd, input bit [1:0] addr, input bit [31:0] wd,
                            output bit [31:0] rdv);
    bit vse, dr, df, set_irq;
    int nshort;
    vse = vs && !m_pvs;
    dr  = de && !m_pde;
    df  = !de && m_pde;
    rdv = rd ? read_reg(addr) : 32'd0;
    if (df) m_lens.push_back((m_cur_len > 4095) ? 4095 : m_cur_len);
    if (dr) m_cur_len = 1;
    else if (de) m_cur_len++;
    set_irq = 0;
    if (vse) begin
      nshort = 0;
      foreach (m_lens[i]) if (m_lens[i] < H) nshort++;
      m_st_lines = (m_lens.size() > 4095) ? 4095 : m_lens.size();
      m_st_short = (nshort > 4095) ? 4095 : nshort;
      m_lens.delete();
      set_irq = m_sh_irqen && (nshort != 0);
      m_mode  = eff_mode(m_sh_mode);
      m_color = m_sh_color;
      if (m_en) begin
        m_frames = (m_frames + 1) % 65536;
        m_on_edges++;
        if (m_on_edges >= MINF && !m_sh_en) m_en = 0;
      end else if (m_sh_en) begin
        m_en = 1;
        m_on_edges = 0;
      end
    end
    if (set_irq) m_irq = 1;
    else if (wr && addr == 2'd2 && wd[24]) m_irq = 0;
    if (wr) begin
      case (addr)
        2'd0:    {m_sh_irqen, m_sh_mode, m_sh_en} = wd[3:0];
        2'd1:    m_sh_color = wd[23:0];
        2'd3:    m_frames = 0;
        default: ;
      endcase
    end
    m_pvs = vs;
    m_pde = de;
  endtask

  task automatic step(input bit vs, de, wr, rd, input bit [1:0] addr, input bit [31:0] wd, input bit rst);
    bit [31:0] rdv;
    @(posedge pre_clk);
    #1;
    bus.pre_vs    = vs;
    bus.pre_de    = de;
    bus.cfg_wr    = wr;
    bus.cfg_rd    = rd;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = wd;
    rst_n         = !rst;
    if (rst) begin
      // Asynchronous reset: the state already expected for this cycle is replaced by reset values.
      m_reset();
      if (exp_q.size() > 0 && exp_q[$].cyc == cyc) void'(exp_q.pop_back());
      exp_q.push_back(snap(cyc, 1'b1, 32'd0));
      exp_q.push_back(snap(cyc + 1, 1'b1, 32'd0));
    end else begin
      model_step(vs, de, wr, rd, addr, wd, rdv);
      exp_q.push_back(snap(cyc + 1, rd, rdv));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 2'd0, 32'd0, 0);
  endtask

  task automatic wreg(input bit [1:0] a, input bit [31:0] d);
    step(0, 0, 1, 0, a, d, 0);
  endtask

  task automatic rreg(input bit [1:0] a);
    step(0, 0, 0, 1, a, 32'd0, 0);
  endtask

  task automatic vsp();
    step(1, 0, 0, 0, 2'd0, 32'd0, 0);
    step(1, 0, 0, 0, 2'd0, 32'd0, 0);
    idle(2);
  endtask

  task automatic line(input int len);
    repeat (len) step(0, 1, 0, 0, 2'd0, 32'd0, 0);
    idle(3);
  endtask

  task automatic rst_pulse(input int n);
    repeat (n) step(0, 0, 0, 0, 2'd0, 32'd0, 1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge pre_clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk("fill_en",    32'(bus.fill_en),    32'(e.en));
      chk("fill_mode",  32'(bus.fill_mode),  32'(e.mode));
      chk("fill_color", 32'(bus.fill_color), 32'(e.color));
      chk("busy",       32'(bus.busy),       32'(e.busy));
      chk("irq",        32'(bus.irq),        32'(e.irq));
      if (e.rd_chk) chk("cfg_rdata", bus.cfg_rdata, e.rdata);
    end
  end

  initial begin
    bit        de_r;
    bit        vs_r;
    int        op;
    bus.pre_vs = 0; bus.pre_de = 0; bus.cfg_wr = 0; bus.cfg_rd = 0;
    bus.cfg_addr = 2'd0; bus.cfg_wdata = 32'd0;
    rst_n = 1'b1;
    m_reset();
    #2 rst_n = 1'b0;
    rst_pulse(3);
    idle(2);
    rreg(2'd2); rreg(2'd3); rreg(2'd0);

    // Commit timing: writes mid-frame become visible only after the next frame start.
    vsp();
    line(20);
    wreg(2'd0, 32'h7);
    wreg(2'd1, 32'h0012_AB34);
    idle(3);
    vsp();
    rreg(2'd0); rreg(2'd1);

    // Minimum hold: drop en_req one frame after enabling.
    wreg(2'd0, 32'h6);
    repeat (6) begin
      vsp();
      idle(2);
    end
    rreg(2'd3);

    // Short-line IRQ with lines of 16, 10, 16 pixels.
    wreg(2'd0, 32'hA);
    vsp();
    line(16); line(10); line(16);
    vsp();
    rreg(2'd2);
    wreg(2'd2, 32'h0100_0000);
    idle(1);
    rreg(2'd2);

    // Write coincident with the frame start is deferred to the following frame.
    step(1, 0, 1, 0, 2'd0, 32'h4, 0);
    step(1, 0, 0, 0, 2'd0, 32'd0, 0);
    idle(5);
    vsp();

    // Boundary: a line ending on the frame start, and a line already active at frame start.
    line(12);
    repeat (5) step(0, 1, 0, 0, 2'd0, 32'd0, 0);
    step(1, 0, 0, 0, 2'd0, 32'd0, 0);
    idle(3);
    rreg(2'd2);
    repeat (3) step(0, 1, 0, 0, 2'd0, 32'd0, 0);
    step(1, 1, 0, 0, 2'd0, 32'd0, 0);
    step(1, 1, 0, 0, 2'd0, 32'd0, 0);
    idle(2);
    vsp();
    rreg(2'd2);

    // Mode 00 commits as black, then reset asserted mid-line.
    wreg(2'd0, 32'h0);
    vsp();
    rreg(2'd0);
    repeat (5) step(0, 1, 0, 0, 2'd0, 32'd0, 0);
    rst_pulse(2);
    idle(2);
    rreg(2'd2); rreg(2'd3); rreg(2'd0);
    wreg(2'd0, 32'h5);
    vsp();

    // Randomized traffic with one reset in the middle.
    de_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_pulse(2);
        de_r = 0;
      end
      vs_r = ((i % 97) < 2);
      if ($urandom_range(0, 6) == 0) de_r = !de_r;
      op = $urandom_range(0, 9);
      step(vs_r, de_r, op == 0, op == 1, 2'($urandom_range(0, 3)), $urandom, 0);
    end

    idle(3);
    repeat (3) @(negedge pre_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
